sram_be_pipe: RTL and testbench
===============================

Name: sram_be_pipe

Overview:
Parametrised single-port synchronous memory; successor to the team's 16x32 register-file memory.
- Adds per-byte write enables, a valid/ready request handshake and a configurable read pipeline (1 or 2 cycles).
- Adds a sequenced clear engine that initialises the whole array one word per cycle, after reset and on demand.
- Serves as the generic local-storage block behind scoreboard/config register banks in the verification-training designs.

Parameters:
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; must be a multiple of 8
READ_LATENCY, 1, cycles from read acceptance to rd_valid; legal values 1 or 2
CLEAR_VALUE, 0, word written to every location by the clear engine

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
clear  in  1  single-cycle request to re-initialise the array (honoured only in READY)
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_be  in  DATA_WIDTH/8  byte enables; bit i covers bits [8i+7:8i]
rd_valid  out  1  one-cycle pulse; rd_data valid this cycle
rd_data  out  DATA_WIDTH  read data; holds its last value between pulses
busy  out  1  high while the clear engine runs

Behaviour:
- States: INIT (clearing), READY.
- rst=1 at an edge: state <= INIT, clear counter <= 0, rd_valid <= 0, rd_data <= 0, read pipeline flushed.
- rst mid-clear restarts the counter at 0. rst mid-read drops the in-flight read; no rd_valid is produced for it.
- INIT: each cycle writes CLEAR_VALUE to mem[cnt] and increments cnt.
  - After the cycle that writes DEPTH-1, state <= READY.
  - INIT therefore lasts exactly DEPTH cycles.
  - busy = (state==INIT); req_ready = 0 throughout INIT.
- READY: req_ready = !clear (combinational).
  - clear=1 in READY: state <= INIT, cnt <= 0.
  - A request presented in that same cycle is not accepted, because req_ready=0.
- Write accept: for each i with req_be[i]=1, mem[addr] byte i <= req_wdata byte i. Other bytes are unchanged. be=0 is accepted as a no-op.
- Read accept: mem[addr] is sampled at the acceptance edge (read-first).
  - A write to the same address in a later cycle does not alter that result.
  - rd_valid rises READ_LATENCY cycles after the acceptance edge, for exactly one cycle.
  - Back-to-back reads give back-to-back rd_valid pulses (throughput 1/cycle).
- clear accepted while reads are in flight: in-flight reads still complete with pre-clear data; the clear engine starts next cycle.
- Address wrap: cnt wraps only via the state transition. req_addr is always in range (DEPTH = 2**ADDR_WIDTH).
- No backpressure on the read-return side: the consumer must accept every rd_valid pulse.
- Illegal READ_LATENCY or DATA_WIDTH%8!=0: elaboration-time assertion/error.

Decomposition:
- Package sram_pkg:
  - state_t enum {INIT, READY}.
  - Function strb_width(dw) = dw/8.
  - Default-parameter localparams.
- Sub-module sram_clear_seq: INIT/READY FSM, address counter, busy, wr-select mux (clear vs. request).
- Array, byte-enable merge and read pipeline stay in the top module.

Test Plan:
- Reset then idle, defaults: busy=1 and req_ready=0 for 16 cycles. Then busy=0, req_ready=1. Reads of addr 0..15 all return 0x00000000.
- Write 0xDEADBEEF to addr 3 with be=4'b1111, then write 0x11223344 to addr 3 with be=4'b0101. A read of addr 3 returns 0xDE22BE44, with rd_valid exactly 1 cycle after acceptance (READ_LATENCY=1) or 2 cycles (READ_LATENCY=2).
- Read addr 5 (holding 0xA5A5A5A5), and in the next cycle write 0x0 to addr 5. Expect rd_data=0xA5A5A5A5. Four back-to-back reads of addr 0..3 give four consecutive rd_valid pulses.
- Fill memory, then pulse clear during a READ_LATENCY=2 read of addr 7 (0x77). Expect: the read returns 0x77; busy high for 16 cycles; all locations then read CLEAR_VALUE. A request asserted in the clear cycle sees req_ready=0 and is not accepted.
- Assert rst at cycle 8 of INIT. Expect INIT to restart with a full 16 busy cycles, and rd_valid to stay 0.
- Assert rst one cycle after a read acceptance. Expect no rd_valid pulse for that read, and rd_data to read 0 after reset.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, defaults and helpers for the byte-enable SRAM
package sram_pkg;

    // Clear engine states: INIT walks the array writing the clear word, READY serves requests
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_READ_LATENCY = 1;

    // Number of byte lanes in a word of dw bits
    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// rtl/sram_clear_seq.sv - INIT/READY sequencer, clear counter and array write-port select
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             req_valid,
    input  logic                             req_we,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] req_be,
    output logic                             req_ready,
    output logic                             busy,
    output logic                             rd_accept,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic [strb_width(DATA_WIDTH)-1:0] mem_be
);

    localparam int                    BW       = strb_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  accept;

    // Sequencer: reset or an honoured clear restarts the walk at word 0; the last word hands over to READY
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= READY;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (clear) begin
                        state <= INIT;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // A clear request steals the cycle, so no request can slip in alongside it
    assign req_ready = (state == READY) && !clear;
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we && !rst;

    // Write port select: the clear engine owns the array in INIT, accepted writes own it in READY
    always_comb begin
        mem_we    = accept && req_we && !rst;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_be    = req_be;
        if (state == INIT) begin
            mem_we    = !rst;
            mem_addr  = cnt;
            mem_wdata = CLEAR_VALUE;
            mem_be    = {BW{1'b1}};
        end
    end

endmodule

// File: rtl/sram_be_pipe.sv
// rtl/sram_be_pipe.sv - single-port SRAM with byte enables, handshake, clear engine and read pipeline
module sram_be_pipe
    import sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int                    READ_LATENCY = DEF_READ_LATENCY,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] req_be,
    output logic                             rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             busy
);

    localparam int BW    = strb_width(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Refuse to build with a latency the pipeline does not implement or a non-byte word
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_be_pipe: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("sram_be_pipe: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  rd_accept;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BW-1:0]         mem_be;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    sram_clear_seq #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .CLEAR_VALUE (CLEAR_VALUE)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_ready (req_ready),
        .busy      (busy),
        .rd_accept (rd_accept),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    // Array write with per-byte merge; disabled lanes keep their previous contents
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BW; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // First read stage: capture the word at the acceptance edge, before any later write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_data <= mem[req_addr];
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        // Second read stage: delay the pulse one cycle, holding data between pulses
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
    end else begin : g_lat1
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end

endmodule

// File: tb/tb_sram_be_pipe.sv
// tb/tb_sram_be_pipe.sv - scoreboard testbench for sram_be_pipe
module tb_sram_be_pipe;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int RL    = 2;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;

    sram_be_pipe #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .CLEAR_VALUE  ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] model [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: check returns, then record what the coming edge will do
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: rd_valid with data %h at cycle %0d, none expected", rd_data, cyc);
            end else begin
                e = q.pop_front();
                if (rd_data !== e.data || cyc != e.due) begin
                    bad++;
                    $display("FAIL rd_return: got %h at cycle %0d, expected %h at cycle %0d", rd_data, cyc, e.data, e.due);
                end
            end
        end else if (q.size() > 0 && q[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL rd_missing: no rd_valid by cycle %0d, expected %h at cycle %0d", cyc, q[0].data, q[0].due);
            void'(q.pop_front());
        end
        if (rst) begin
            q.delete();
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) model[i] = '0;
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    for (int i = 0; i < BW; i++) begin
                        if (req_be[i]) model[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
                    end
                end else begin
                    q.push_back('{model[req_addr], cyc + RL});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic do_write(input int addr, input logic [DW-1:0] data, input logic [BW-1:0] be);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = AW'(addr);
        req_wdata = data;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic read_burst(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(first + i);
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d reads outstanding, expected 0", name, q.size());
        end
    endtask

    task automatic count_busy(input string name, input int expect_n);
        int n       = 0;
        int rdy_bad = 0;
        bit done    = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                if (req_ready !== 1'b0) rdy_bad++;
            end else begin
                done = 1;
            end
        end
        total++;
        if (n != expect_n) begin
            bad++;
            $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, n, expect_n);
        end
        total++;
        if (rdy_bad != 0) begin
            bad++;
            $display("FAIL %s_ready_in_init: req_ready high in %0d busy cycles, expected 0", name, rdy_bad);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready_after: req_ready=%b, expected 1", name, req_ready);
        end
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b, expected 0", rd_valid); end
        total++;
        if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %h, expected 0", rd_data); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b, expected 1", busy); end
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready); end
        tick();
        rst = 1'b0;
        count_busy("init", DEPTH);
        read_burst(0, DEPTH);
        drain("init_reads");
    endtask

    task automatic test_byte_enable();
        do_write(3, 32'hDEADBEEF, 4'b1111);
        do_write(3, 32'h11223344, 4'b0101);
        read_burst(3, 1);
        drain("byte_enable");
        total++;
        if (rd_data !== 32'hDE22BE44) begin
            bad++;
            $display("FAIL byte_enable_data: got %h, expected de22be44", rd_data);
        end
        do_write(3, 32'hFFFFFFFF, 4'b0000);
        read_burst(3, 1);
        drain("be_zero");
        total++;
        if (rd_data !== 32'hDE22BE44) begin
            bad++;
            $display("FAIL be_zero_data: got %h, expected de22be44", rd_data);
        end
    endtask

    task automatic test_read_first();
        do_write(5, 32'hA5A5A5A5, 4'b1111);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd5;
        tick();
        req_we    = 1'b1;
        req_wdata = '0;
        req_be    = 4'b1111;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        drain("read_first");
        total++;
        if (rd_data !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL read_first_data: got %h, expected a5a5a5a5", rd_data);
        end
        read_burst(5, 1);
        drain("read_after_write");
        total++;
        if (rd_data !== 32'h0) begin
            bad++;
            $display("FAIL read_after_write_data: got %h, expected 00000000", rd_data);
        end
    endtask

    task automatic test_back_to_back();
        int n     = 0;
        int first = -1;
        int last  = -1;
        for (int i = 0; i < 4; i++) do_write(i, 32'h0101_0101 * (i + 1), 4'b1111);
        fork
            read_burst(0, 4);
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (rd_valid) begin
                        n++;
                        if (first < 0) first = cyc;
                        last = cyc;
                    end
                end
            end
        join
        drain("back_to_back");
        total++;
        if (n != 4 || last - first != 3) begin
            bad++;
            $display("FAIL back_to_back_pulses: got %0d pulses over %0d cycles, expected 4 over 4", n, last - first + 1);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < DEPTH; i++) do_write(i, 32'(i * 17), 4'b1111);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd7;
        tick();
        clear     = 1'b1;
        req_addr  = 4'd1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL clear_cycle_ready: got %b, expected 0", req_ready);
        end
        tick();
        clear     = 1'b0;
        req_valid = 1'b0;
        count_busy("clear", DEPTH);
        drain("clear_inflight");
        total++;
        if (rd_data !== 32'h77) begin
            bad++;
            $display("FAIL clear_inflight_data: got %h, expected 00000077", rd_data);
        end
        read_burst(0, DEPTH);
        drain("clear_reads");
    endtask

    task automatic test_reset_mid_init();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy("init_restart", DEPTH);
    endtask

    task automatic test_reset_mid_read();
        do_write(9, 32'h12345678, 4'b1111);
        read_burst(9, 1);
        drain("pre_reset_read");
        total++;
        if (rd_data !== 32'h12345678) begin
            bad++;
            $display("FAIL pre_reset_data: got %h, expected 12345678", rd_data);
        end
        read_burst(9, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rd_data !== '0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_read: got rd_valid=%b rd_data=%h, expected 0 and 00000000", rd_valid, rd_data);
        end
        tick();
        count_busy("post_reset", DEPTH - 1);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_byte_enable();
        test_read_first();
        test_back_to_back();
        test_clear();
        test_reset_mid_init();
        test_reset_mid_read();
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
